d_en: RTL and testbench

D_EN -- requirements
Module: d_en

---
 rtl/d_en.sv | 55 +++++
 tb/tb_d_en.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/d_en.sv
// d_en: WIDTH-bit data element with enable, built either as a level-sensitive
// transparent latch (MODE=0) or a rising-edge register (MODE=1).
// Both forms have an asynchronous active-low reset that loads RST_VAL.
// Qn is always the bitwise complement of Q. Every bit is independent.
`timescale 1ns/1ps
module d_en #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter bit               MODE    = 1'b0
) (
  input  logic             C,
  input  logic             Rn,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  // Stored value and the value it would take on the next load. D feeds each
  // bit straight through, so no bit depends on any other bit.
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state value: plain data input with no cross-bit logic.
  always_comb begin
    q_d = D;
  end

  if (MODE == 1'b0) begin : g_latch
    // Transparent latch: reset wins, otherwise follow D while C is high and
    // hold the last value passed through once C falls.
    always_latch begin
      if (!Rn) begin
        q_q <= RST_VAL;
      end else if (C) begin
        q_q <= q_d;
      end
    end
  end else begin : g_flop
    // Edge register: reset wins asynchronously, otherwise capture D on each
    // rising edge of C. A release of Rn while C is already high is not an edge.
    always_ff @(posedge C or negedge Rn) begin
      if (!Rn) begin
        q_q <= RST_VAL;
      end else begin
        q_q <= q_d;
      end
    end
  end

  // Both outputs come from the same stored value so they can never agree on
  // any bit, including during reset.
  assign Q  = q_q;
  assign Qn = ~q_q;

endmodule

// File: tb/tb_d_en.sv
// tb_d_en: directed and randomized checks of d_en in three configurations:
// a 1-bit latch, an 8-bit latch and an 8-bit edge register (both 8-bit
// instances reset to 8'hA5). Expected outputs come from a behavioural model.
`timescale 1ns/1ps
module tb_d_en;

  logic       c_s  = 1'b0;
  logic       rn_s = 1'b1;
  logic       d1_s = 1'b0;
  logic [7:0] d8_s = 8'h00;

  logic       q1, qn1;
  logic [7:0] ql8, qnl8, qf8, qnf8;

  // Behavioural model state.
  logic       m1;
  logic [7:0] ml8, mf8;
  logic       prev_c;

  int n_chk = 0;
  int n_err = 0;

  d_en #(.WIDTH(1), .RST_VAL(1'b0), .MODE(1'b0)) u_lat1 (
    .C(c_s), .Rn(rn_s), .D(d1_s), .Q(q1), .Qn(qn1));
  d_en #(.WIDTH(8), .RST_VAL(8'hA5), .MODE(1'b0)) u_lat8 (
    .C(c_s), .Rn(rn_s), .D(d8_s), .Q(ql8), .Qn(qnl8));
  d_en #(.WIDTH(8), .RST_VAL(8'hA5), .MODE(1'b1)) u_ff8 (
    .C(c_s), .Rn(rn_s), .D(d8_s), .Q(qf8), .Qn(qnf8));

  // Model rules: reset forces the reset value; a latch passes D while C is
  // high; a register loads D only on a 0->1 change of C while out of reset.
  task automatic model_update();
    if (!rn_s) begin
      m1  = 1'b0;
      ml8 = 8'hA5;
      mf8 = 8'hA5;
    end else begin
      if (c_s) begin
        m1  = d1_s;
        ml8 = d8_s;
      end
      if (c_s && !prev_c) mf8 = d8_s;
    end
    prev_c = c_s;
  endtask

  task automatic check(input string tag);
    n_chk++;
    assert (q1 === m1) else begin
      n_err++; $error("FAIL %s lat1.Q observed %h expected %h", tag, q1, m1);
    end
    n_chk++;
    assert (qn1 === ~m1) else begin
      n_err++; $error("FAIL %s lat1.Qn observed %h expected %h", tag, qn1, ~m1);
    end
    n_chk++;
    assert (ql8 === ml8) else begin
      n_err++; $error("FAIL %s lat8.Q observed %h expected %h", tag, ql8, ml8);
    end
    n_chk++;
    assert (qnl8 === ~ml8) else begin
      n_err++; $error("FAIL %s lat8.Qn observed %h expected %h", tag, qnl8, ~ml8);
    end
    n_chk++;
    assert (qf8 === mf8) else begin
      n_err++; $error("FAIL %s ff8.Q observed %h expected %h", tag, qf8, mf8);
    end
    n_chk++;
    assert (qnf8 === ~mf8) else begin
      n_err++; $error("FAIL %s ff8.Qn observed %h expected %h", tag, qnf8, ~mf8);
    end
  endtask

  // Wait, apply a new input set, update the model and check 1 ns later.
  task automatic drive(input int dly, input logic c, input logic rn,
                       input logic d1, input logic [7:0] d8, input string tag);
    #dly;
    c_s  = c;
    rn_s = rn;
    d1_s = d1;
    d8_s = d8;
    model_update();
    #1;
    check(tag);
  endtask

  initial begin
    logic       nc, nrn, nd1;
    logic [7:0] nd8;
    m1 = 1'b0; ml8 = 8'h00; mf8 = 8'h00; prev_c = 1'b0;

    // Reset and release with C low: hold reset value.
    drive(5,  1'b0, 1'b0, 1'b0, 8'h00, "reset");
    drive(5,  1'b1, 1'b0, 1'b1, 8'h00, "c_high_in_reset");
    drive(5,  1'b0, 1'b0, 1'b1, 8'h00, "c_low_in_reset");
    drive(5,  1'b0, 1'b0, 1'b0, 8'h00, "d_low_in_reset");
    drive(10, 1'b0, 1'b1, 1'b0, 8'h00, "release_c_low");
    drive(10, 1'b0, 1'b1, 1'b0, 8'h3C, "d_change_c_low");
    drive(10, 1'b1, 1'b1, 1'b0, 8'h3C, "c_rise_load_3c");

    // Latch timing: D rises while C low, then C rises; D falls while C low.
    drive(10, 1'b0, 1'b1, 1'b0, 8'h3C, "c_fall");
    drive(40, 1'b0, 1'b1, 1'b1, 8'h3C, "d_up_c_low_hold");
    drive(10, 1'b1, 1'b1, 1'b1, 8'h3C, "c_rise_pass_1");
    drive(50, 1'b0, 1'b1, 1'b1, 8'h3C, "c_fall_hold_1");
    drive(10, 1'b0, 1'b1, 1'b0, 8'h3C, "d_down_c_low_hold");
    drive(40, 1'b1, 1'b1, 1'b0, 8'h3C, "c_rise_pass_0");

    // D pulse while transparent, then the same pulse while holding.
    drive(10, 1'b1, 1'b1, 1'b1, 8'hC3, "pulse_transp_hi");
    drive(20, 1'b1, 1'b1, 1'b0, 8'h3C, "pulse_transp_lo");
    drive(10, 1'b0, 1'b1, 1'b0, 8'h3C, "c_fall_before_pulse");
    drive(10, 1'b0, 1'b1, 1'b1, 8'hFF, "pulse_hold_hi");
    drive(20, 1'b0, 1'b1, 1'b0, 8'h3C, "pulse_hold_lo");

    // Reset pulse while transparent, then release with C still high.
    drive(10, 1'b1, 1'b1, 1'b1, 8'h3C, "transp_before_rst");
    drive(5,  1'b1, 1'b0, 1'b1, 8'h3C, "rst_overrides_transp");
    drive(10, 1'b1, 1'b1, 1'b1, 8'h3C, "release_c_high");

    // Register: D set and cleared while C high, then edges with D held.
    drive(10, 1'b1, 1'b1, 1'b1, 8'hFF, "ff_d_set_c_high");
    drive(10, 1'b1, 1'b1, 1'b1, 8'h00, "ff_d_clear_c_high");
    drive(10, 1'b0, 1'b1, 1'b1, 8'h00, "ff_c_fall");
    drive(10, 1'b1, 1'b1, 1'b1, 8'h00, "ff_rise_d0");
    drive(10, 1'b0, 1'b1, 1'b1, 8'h00, "ff_c_fall2");
    drive(10, 1'b0, 1'b1, 1'b1, 8'hFF, "ff_d_set_c_low");
    drive(10, 1'b1, 1'b1, 1'b1, 8'hFF, "ff_rise_dff");
    drive(10, 1'b0, 1'b1, 1'b1, 8'hFF, "ff_fall_no_effect");
    drive(10, 1'b0, 1'b1, 1'b0, 8'h12, "ff_d_change_low");

    // Randomized: change exactly one input per step.
    for (int i = 0; i < 400; i++) begin
      int sel;
      nc = c_s; nrn = rn_s; nd1 = d1_s; nd8 = d8_s;
      sel = int'($urandom_range(0, 15));
      if (sel == 0)       nrn = ~rn_s;
      else if (sel < 7)   nc  = ~c_s;
      else if (sel < 11)  nd1 = 1'($urandom);
      else                nd8 = 8'($urandom);
      drive(int'($urandom_range(1, 20)), nc, nrn, nd1, nd8, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
